// File: rtl/fire_pkg.sv
// Shared constants and types for the fire-stage bias/activation blocks.
package fire_pkg;

    localparam int unsigned NCH   = 128;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned SHIFT = 8;
    localparam int unsigned CH_W  = $clog2(NCH);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef logic signed [SUM_W-1:0] sum_t;

endpackage

// File: rtl/relu_requant.sv
// Combinational ReLU, round-half-up requantisation and positive saturation.
module relu_requant #(
    parameter int unsigned IN_W  = 33,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 8
) (
    input  logic [IN_W-1:0]  sum,
    output logic [OUT_W-1:0] result
);

    // One guard bit so the rounding add cannot overflow the largest positive sum.
    localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic [IN_W:0] MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};

    logic [IN_W:0] rounded;
    logic [IN_W:0] shifted;

    always_comb begin
        rounded = {sum[IN_W-1], sum} + RND;
        shifted = rounded >> SHIFT;
        if (sum[IN_W-1]) begin
            result = '0;
        end else if (shifted > MAX) begin
            result = MAX[OUT_W-1:0];
        end else begin
            result = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/bias_relu_fire5_expand1.sv
// Two-stage bias add + ReLU/requantise pipeline for fire5 expand1, with channel
// tracking and a sticky alignment error.
module bias_relu_fire5_expand1
    import fire_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NCH-1:0][ACC_W-1:0]  bias_mem,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ACC_W-1:0]           in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [CH_W-1:0]            out_ch,
    output logic                       out_last,
    output logic                       ch_err
);

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

    logic [CH_W-1:0]  ch;
    logic             s1_valid;
    sum_t             s1_sum;
    logic [CH_W-1:0]  s1_ch;
    logic             s2_adv;
    logic             in_fire;
    logic             ch_at_end;
    sum_t             in_sum;
    logic [OUT_W-1:0] s2_result;

    assign s2_adv    = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign in_fire   = in_valid && in_ready;
    assign ch_at_end = (ch == CH_LAST);
    assign in_sum    = {in_data[ACC_W-1], in_data} + {bias_mem[ch][ACC_W-1], bias_mem[ch]};

    // in_last and the final channel must coincide; either one alone is an error,
    // and both force the next word back to channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch     <= '0;
            ch_err <= 1'b0;
        end else if (in_fire) begin
            if (in_last || ch_at_end) begin
                ch <= '0;
            end else begin
                ch <= ch + CH_W'(1);
            end
            if (in_last != ch_at_end) begin
                ch_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_ch    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_sum   <= in_sum;
            s1_ch    <= ch;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    relu_requant #(
        .IN_W  (SUM_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_relu_requant (
        .sum    (s1_sum),
        .result (s2_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s2_result;
                out_ch   <= s1_ch;
                out_last <= (s1_ch == CH_LAST);
            end
        end
    end

endmodule

// File: tb/tb_bias_relu_fire5_expand1.sv
// Scoreboard bench: randomized words are scored against an arithmetic reference.
module tb_bias_relu_fire5_expand1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [127:0][31:0]  bias;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [31:0]         in_data = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [15:0]         out_data;
    logic [6:0]          out_ch;
    logic                out_last;
    logic                ch_err;

    typedef struct {
        logic [15:0] data;
        logic [6:0]  ch;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned ch_m = 0;
    bit          rand_rdy = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] pd;
    logic [6:0]  pc;
    logic        pl;

    bias_relu_fire5_expand1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bias_mem  (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .ch_err    (ch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Reference: signed sum, ReLU, round half up, drop 8 fractional bits, clamp.
    function automatic logic [15:0] ref_act(input logic [31:0] d, input logic [31:0] b);
        longint s;
        longint r;
        s = longint'($signed(d)) + longint'($signed(b));
        if (s < 0) return 16'd0;
        r = (s + 128) / 256;
        if (r > 32767) r = 32767;
        return 16'(r);
    endfunction

    function automatic logic [31:0] rnd_data();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'(int'($urandom_range(0, 200000)) - 100000);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int unsigned g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && g < 1000) begin
            step();
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{ref_act(d, bias[ch_m]), 7'(ch_m), (ch_m == 127)});
        ch_m = (l || ch_m == 127) ? 0 : ch_m + 1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int unsigned g = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && g < 5000) begin
            step();
            g++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_ch_err", 64'(ch_err), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        sb.delete();
        ch_m = 0;
        in_valid = 1'b0;
        in_last = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || out_data !== pd || out_ch !== pc || out_last !== pl) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0h ch=%0d l=%0b expected v=1 d=%0h ch=%0d l=%0b",
                             out_valid, out_data, out_ch, out_last, pd, pc, pl);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got ch=%0d expected none", out_ch);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_ch", 64'(out_ch), 64'(e.ch));
                    check("out_last", 64'(out_last), 64'(e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pc = out_ch;
            pl = out_last;
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) bias[i] = 32'(int'($urandom_range(0, 4000)) - 2000);
        bias[0] = 32'h22A;
        bias[1] = 32'hFFFF_FFCE;
        bias[5] = 32'd122;
        step();
        do_reset();

        // Basic requantisation and two-cycle latency with out_ready held high.
        out_ready = 1'b1;
        send(32'h100, 1'b0);
        check("lat_cycle1_valid", 64'(out_valid), 64'd0);
        step();
        check("lat_cycle2_valid", 64'(out_valid), 64'd1);
        check("lat_out_data", 64'(out_data), 64'd3);
        check("lat_out_ch", 64'(out_ch), 64'd0);

        // Remainder of the pixel under random backpressure: clamp, saturation, order.
        rand_rdy = 1'b1;
        send(32'd10, 1'b0);
        for (int i = 2; i < 5; i++) send(rnd_data(), 1'b0);
        send(32'h7FFF_FFFF, 1'b0);
        for (int i = 6; i < 128; i++) send(rnd_data(), i == 127);
        drain();
        check("pixel1_ch_err", 64'(ch_err), 64'd0);

        for (int i = 0; i < 128; i++) send(rnd_data(), i == 127);
        drain();
        check("pixel2_ch_err", 64'(ch_err), 64'd0);

        // Misaligned last on channel 10.
        for (int i = 0; i <= 10; i++) send(rnd_data(), i == 10);
        send(rnd_data(), 1'b0);
        drain();
        check("misaligned_ch_err", 64'(ch_err), 64'd1);

        // Reset with both stages full at channel 60.
        rand_rdy = 1'b0;
        step();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) send(rnd_data(), 1'b0);
        out_ready = 1'b0;
        step();
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        do_reset();
        out_ready = 1'b1;
        send(rnd_data(), 1'b0);
        step();
        check("post_reset_out_ch", 64'(out_ch), 64'd0);
        drain();

        // Final channel reached without in_last.
        rand_rdy = 1'b1;
        for (int i = 0; i < 128; i++) send(rnd_data(), 1'b0);
        send(rnd_data(), 1'b0);
        drain();
        check("missing_last_ch_err", 64'(ch_err), 64'd1);

        rand_rdy = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bias_relu_fire5_expand1.md
BIAS_RELU_FIRE5_EXPAND1 -- requirements
Module: bias_relu_fire5_expand1

Interface
REQ-001 Parameters SHALL be: NCH 128, number of output channels; ACC_W 32, accumulator and bias width; OUT_W 16, activation width; SHIFT 8, fractional bits dropped at requantisation.
REQ-002 Ports SHALL be:
- clk  in  1  the single clock; all logic rises on it.
- rst_n  in  1  asynchronous, active-low reset.
- bias_mem  in  ACC_W x NCH  per-channel signed bias, driven by biasing_fire5_expand1.
- in_valid  in  1  accumulator word valid.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  ACC_W  signed convolution accumulator for the current channel.
- in_last  in  1  marks the final channel of a pixel.
- out_valid  out  1  activation valid.
- out_ready  in  1  consumer accepts.
- out_data  out  OUT_W  post-ReLU activation, unsigned value in a signed container.
- out_ch  out  7  channel index of out_data.
- out_last  out  1  out_ch == NCH-1.
- ch_err  out  1  sticky channel-alignment error.

Function
REQ-003 A channel counter ch SHALL increment on each input handshake (in_valid && in_ready), wrapping from NCH-1 to 0.
REQ-004 Stage 1 SHALL register the 33-bit sign-extended sum in_data + bias_mem[ch], together with ch, on the input handshake.
REQ-005 Stage 2 SHALL compute the result from the stage 1 sum:
- if the sum is negative, the result is 0;
- otherwise the result is (sum + 2^(SHIFT-1)) >> SHIFT, saturated to 2^(OUT_W-1)-1;
- out_ch and out_last are carried alongside the result.
REQ-006 Latency SHALL be exactly 2 cycles from the input handshake to out_valid when out_ready is held high; throughput SHALL be 1 word per cycle.
REQ-007 The pipeline SHALL stall when out_valid && !out_ready. While stalled, out_data, out_ch and out_last SHALL hold stable and no data SHALL be dropped or duplicated.
REQ-008 in_ready SHALL be high when stage 1 is empty, or when stage 1 can advance because stage 2 is empty or out_ready is high.
REQ-009 If in_last is seen on a handshake with ch != NCH-1, ch_err SHALL set and stay set until reset. The counter SHALL then resynchronise to 0 on the next handshake.
REQ-010 If ch == NCH-1 is reached without in_last, ch_err SHALL set and the counter SHALL still wrap to 0.
REQ-011 A simultaneous input handshake and output handshake SHALL both complete in the same cycle with no bubble.
REQ-012 bias_mem SHALL be treated as static and read combinationally, with no registering.

Reset
REQ-013 Assertion of rst_n low SHALL, asynchronously: clear both stage valids, ch, and ch_err; set out_valid to 0, out_data to 0, out_ch to 0 and out_last to 0.
REQ-014 in_ready SHALL read 1 after reset.
REQ-015 A reset asserted mid-pixel SHALL discard all in-flight words, and the first handshake after release SHALL be channel 0.

Structure
REQ-016 NCH, ACC_W, OUT_W, SHIFT and a typedef for the 33-bit sum SHALL live in a shared package, fire_pkg, which the other fire-stage blocks reuse.
REQ-017 The saturate-and-ReLU step SHALL be one combinational sub-module, relu_requant, parameterised by widths and shift, so that the other fire layers can share it.
REQ-018 Implementation size SHALL be about 150-250 lines; no RAM inference.

Verification
REQ-019 Basic requantisation: bias[0]=0x22A, in_data=0x100 at ch 0 -> out_data=3, out_ch=0, out_valid exactly 2 cycles later.
REQ-020 ReLU clamp: bias[1]=-50, in_data=10 -> out_data=0.
REQ-021 Saturation: bias[5]=122, in_data=0x7FFFFFFF -> out_data=0x7FFF with no wrap to negative.
REQ-022 Full pixel with backpressure: stream 128 words with in_last on the final word, toggling out_ready randomly -> 128 outputs in order, out_ch 0..127, out_last only on 127, ch_err=0.
REQ-023 Misaligned last: in_last on ch 10 -> ch_err=1 and the next word is tagged out_ch=0.
REQ-024 Reset mid-stream: reset at ch 60 with both stages full -> out_valid=0 immediately, and the next input is emitted with out_ch=0.
